seq_cla_subtractor: RTL and testbench

SEQ_CLA_SUBTRACTOR -- requirements
Module: seq_cla_subtractor

---
 rtl/seq_cla_subtractor.sv | 108 ++++++++++
 tb/tb_seq_cla_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_cla_subtractor.sv
// Sequential subtractor: computes a-b as a + ~b + 1, one GROUP-bit
// carry-lookahead slice per clock. After WIDTH/GROUP slices it reports
// diff, unsigned borrow and signed overflow with a one-cycle done pulse.
module seq_cla_subtractor #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / GROUP;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             carry;

  logic [GROUP-1:0] sa;
  logic [GROUP-1:0] snb;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] sum;
  logic [GROUP:0]   c;
  int               base;
  logic             last;

  assign base = int'(k) * GROUP;
  assign last = (k == KW'(NSLICE - 1));

  // Carry-lookahead slice k: propagate/generate against the inverted
  // subtrahend, carry-in from the carry register.
  always_comb begin
    sa   = a_q[base +: GROUP];
    snb  = ~b_q[base +: GROUP];
    p    = sa ^ snb;
    g    = sa & snb;
    c    = '0;
    sum  = '0;
    c[0] = carry;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      sum[i] = p[i] ^ c[i];
    end
  end

  // Status decodes straight off the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control FSM and datapath registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      carry  <= 1'b1;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            a_q    <= a;
            b_q    <= b;
            k      <= '0;
            carry  <= 1'b1;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff[base +: GROUP] <= sum;
          carry               <= c[GROUP];
          if (last) begin
            // Carry-out of a + ~b + 1 is the inverse of the unsigned borrow;
            // overflow is the carry disagreement around the MSB.
            state  <= DONE;
            borrow <= ~c[GROUP];
            ovf    <= c[GROUP-1] ^ c[GROUP];
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Bench for seq_cla_subtractor: fixed vectors, randomized operands against
// an arithmetic reference, and hand-written start/reset corner sequences.
module tb_seq_cla_subtractor;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NS = W / G;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  seq_cla_subtractor #(.WIDTH(W), .GROUP(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .borrow(borrow),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction and sign rules.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] md, output logic mbr, output logic mov);
    md  = ma - mb;
    mbr = (ma < mb);
    mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
  endtask

  // One isolated operation: checks busy and the partially filled diff each
  // RUN cycle, then latency and final results.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string nm);
    int n;
    logic [31:0] m;
    @(negedge clk);
    a = ta; b = tb2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      m = (32'h1 << ((n - 1) * G)) - 32'h1;
      chk({nm, "_busy"}, {31'b0, busy}, 32'h1);
      chk({nm, "_partial"}, {16'b0, diff}, {16'b0, ed & m[W-1:0]});
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, NS + 1);
    chk({nm, "_done"}, {31'b0, done}, 32'h1);
    chk({nm, "_busy_off"}, {31'b0, busy}, 32'h0);
    chk({nm, "_diff"}, {16'b0, diff}, {16'b0, ed});
    chk({nm, "_borrow"}, {31'b0, borrow}, {31'b0, eb});
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
  endtask

  initial begin
    logic [W-1:0] ra, rb, ed, ed2;
    logic eb, eo, eb2, eo2;
    int n, t1, t2, pulses;

    checks = 0; failures = 0;
    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_diff", {16'b0, diff}, 32'h0);
    chk("rst_borrow", {31'b0, borrow}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov, $sformatf("vec%0d", i));

    // Results hold in IDLE after the done pulse.
    @(negedge clk);
    chk("idle_hold_diff", {16'b0, diff}, 32'h8001);
    chk("idle_hold_done", {31'b0, done}, 32'h0);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i == 0) rb = ra;
      model(ra, rb, ed, eb, eo);
      run_op(ra, rb, ed, eb, eo, $sformatf("rnd%0d", i));
    end

    // start re-pulsed with new operands during RUN is ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; start = 1'b1;
    @(negedge clk); start = 1'b0;                          // n=1
    @(negedge clk); a = 16'hFFFF; b = 16'h0001; start = 1'b1; // edge 2
    @(negedge clk); a = 16'h0F0F; b = 16'hF0F0;            // edge 3
    @(negedge clk); start = 1'b0;                          // n=4
    pulses = 0; t1 = 0;
    for (int i = 4; i < 14; i++) begin
      if (done) begin
        pulses++;
        t1 = i;
        chk("ign_diff", {16'b0, diff}, 32'h1000);
        chk("ign_borrow", {31'b0, borrow}, 32'h0);
        chk("ign_ovf", {31'b0, ovf}, 32'h0);
      end
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_latency", t1, NS + 1);

    // Reset mid-run (with start also high) aborts with no done pulse.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_diff", {16'b0, diff}, 32'h0);
    chk("abort_borrow", {31'b0, borrow}, 32'h0);
    chk("abort_ovf", {31'b0, ovf}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    chk("abort_quiet", pulses, 0);
    run_op(16'h5555, 16'h1111, 16'h4444, 1'b0, 1'b0, "post_abort");

    // start held through DONE: second operation launches at the DONE edge.
    model(16'h0003, 16'h0005, ed, eb, eo);
    model(16'h8001, 16'h7FFF, ed2, eb2, eo2);
    @(negedge clk);
    a = 16'h0003; b = 16'h0005; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    t1 = n;
    chk("b2b_lat1", t1, NS + 1);
    chk("b2b_diff1", {16'b0, diff}, {16'b0, ed});
    chk("b2b_borrow1", {31'b0, borrow}, {31'b0, eb});
    chk("b2b_ovf1", {31'b0, ovf}, {31'b0, eo});
    a = 16'h8001; b = 16'h7FFF;
    @(negedge clk); n++; start = 1'b0;
    chk("b2b_busy2", {31'b0, busy}, 32'h1);
    while (!done && n < 40) begin @(negedge clk); n++; end
    t2 = n;
    // Four RUN cycles sit between the two one-cycle done pulses.
    chk("b2b_gap", t2 - t1, NS + 1);
    chk("b2b_diff2", {16'b0, diff}, {16'b0, ed2});
    chk("b2b_borrow2", {31'b0, borrow}, {31'b0, eb2});
    chk("b2b_ovf2", {31'b0, ovf}, {31'b0, eo2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
